// File: rtl/dslx_pipeline_rv_pkg.sv
// Shared helpers for the DSLX pipeline valid/ready adapter.
// The payloads are opaque vectors, so this package holds only sizing helpers.
package dslx_pipeline_rv_pkg;

    // ceil(log2(value)), but never less than 1, so a one-entry structure still gets a 1-bit pointer.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Width of the occupancy counters. The extra bit keeps inflight + fifo_cnt from wrapping.
    function automatic int count_width(input int latency, input int depth);
        int biggest;
        biggest = (latency > depth) ? latency : depth;
        return $clog2(biggest + 1) + 1;
    endfunction

endpackage

// File: rtl/dslx_rv_sync_fifo.sv
// Show-ahead synchronous FIFO with modulo-DEPTH pointers. DEPTH need not be a power of two.
// The head entry is always visible on head_data. A push into an empty FIFO
// becomes visible only after the write edge, because there is no bypass path.
module dslx_rv_sync_fifo
    import dslx_pipeline_rv_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW    = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_pop    = pop && (cnt_q != '0);
    assign do_push   = push && (cnt_q != CNT_W'(DEPTH));
    assign head_data = mem_q[rd_ptr_q];
    assign count     = cnt_q;

    // Next-state for pointers, occupancy and storage; push and pop together leave the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state resets asynchronously. Buffered results are discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset because entries are only visible once the count covers them.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Upstream credit accounting makes a write into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && (cnt_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/dslx_pipeline_rv_adapter.sv
// Valid/ready wrapper around a stall-free, fixed-latency DSLX pipeline.
// A valid shift register marks which pipeline slots carry real work.
// Results are captured into a FIFO. Issue is credit-limited, so results are
// never dropped while the downstream stalls.
module dslx_pipeline_rv_adapter
    import dslx_pipeline_rv_pkg::*;
#(
    parameter int IN_W       = 64,
    parameter int OUT_W      = 32,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IN_W-1:0]  pipe_in,
    input  logic [OUT_W-1:0] pipe_out,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW  = count_width(LATENCY, FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      fifo_cnt;
    logic [FCW-1:0]     fifo_count_raw;
    logic               acc;
    logic               pop;
    logic               result_due;

    assign pipe_in    = in_data;
    assign fifo_cnt   = CW'(fifo_count_raw);
    assign in_ready   = !rst && ((inflight + fifo_cnt) < CW'(FIFO_DEPTH));
    assign acc        = in_valid && in_ready;
    assign result_due = vld_sr_q[LATENCY-1];
    assign out_valid  = (fifo_cnt != '0);
    assign pop        = out_valid && out_ready;

    // Count in-flight slots. A pop in the same cycle does not free a credit, which keeps in_ready off the out_ready path.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(vld_sr_q[i]);
        end
    end

    // The valid marker advances every edge because the pipeline never stalls. The cast drops the oldest bit.
    always_comb begin
        vld_sr_d = LATENCY'({vld_sr_q, acc});
    end

    // Clearing the shift register on reset makes any pre-reset results still in the pipeline invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q <= vld_sr_d;
        end
    end

    dslx_rv_sync_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (result_due),
        .push_data (pipe_out),
        .pop       (pop),
        .head_data (out_data),
        .count     (fifo_count_raw)
    );

endmodule
